// File: rtl/adder_operand_sequencer_if.sv
// Switch/button bus for the adder operand sequencer: raw board inputs in,
// operand/result registers and status out.
interface adder_operand_sequencer_if;
    logic [3:0] y;
    logic       pb_load;
    logic       pb_clr;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] sum;
    logic       cout;
    logic       valid;
    logic [2:0] stage;
    logic       load_ack;

    // Board side: drives switches/buttons, observes registers.
    modport master (
        output y, pb_load, pb_clr,
        input  a, b, sum, cout, valid, stage, load_ack
    );

    // Sequencer side.
    modport slave (
        input  y, pb_load, pb_clr,
        output a, b, sum, cout, valid, stage, load_ack
    );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Adder operand sequencer: one load button steps a 4-bit switch bank through
// A[3:0], A[6:4], B[3:0], B[6:4], then computes and presents {cout,sum}=a+b.
// Build option: define ADDER_SEQ_DEBOUNCE_EN to insert the DB_CYCLES debounce
// filter between the synchronisers and the edge detectors; without it the
// edge detectors tap the synchronisers directly and DB_CYCLES/DB_W are unused.
module adder_operand_sequencer #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned DB_W      = 18
) (
    input logic                        clk,
    input logic                        rst_n,
    adder_operand_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        StALo   = 3'd0,
        StAHi   = 3'd1,
        StBLo   = 3'd2,
        StBHi   = 3'd3,
        StCalc  = 3'd4,
        StResult = 3'd5
    } state_e;

    // Bit 0 is the load button, bit 1 the clear button.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] filt_lvl;
    logic [1:0] edge_q;
    logic [1:0] pulse;
    logic       ld_p;
    logic       clr_p;

    state_e     state_q;
    logic [6:0] a_q;
    logic [6:0] b_q;
    logic [6:0] sum_q;
    logic       cout_q;
    logic       valid_q;
    logic       load_ack_q;

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.pb_clr, bus.pb_load};
            sync2_q <= sync1_q;
        end
    end

`ifdef ADDER_SEQ_DEBOUNCE_EN
    logic [1:0][DB_W-1:0] db_cnt_q;
    logic [1:0]           db_lvl_q;

    // Debounce: adopt the synchronised level after DB_CYCLES equal samples;
    // any sample matching the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            db_lvl_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_lvl_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_lvl_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign filt_lvl = db_lvl_q;
`else
    // Clean-input build: every synchronised edge becomes a pulse.
    assign filt_lvl = sync2_q;
`endif

    // Previous filtered level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= filt_lvl;
        end
    end

    assign pulse = filt_lvl & ~edge_q;
    assign ld_p  = pulse[0];
    assign clr_p = pulse[1];

    // Sequencer FSM with registered operand/result/status outputs; clear wins over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StALo;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            valid_q    <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= ld_p;
            if (clr_p) begin
                state_q <= StALo;
                a_q     <= '0;
                b_q     <= '0;
                sum_q   <= '0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    StALo: begin
                        if (ld_p) begin
                            a_q[3:0] <= bus.y;
                            state_q  <= StAHi;
                        end
                    end
                    StAHi: begin
                        if (ld_p) begin
                            a_q[6:4] <= bus.y[2:0];
                            state_q  <= StBLo;
                        end
                    end
                    StBLo: begin
                        if (ld_p) begin
                            b_q[3:0] <= bus.y;
                            state_q  <= StBHi;
                        end
                    end
                    StBHi: begin
                        if (ld_p) begin
                            b_q[6:4] <= bus.y[2:0];
                            state_q  <= StCalc;
                        end
                    end
                    StCalc: begin
                        {cout_q, sum_q} <= {1'b0, a_q} + {1'b0, b_q};
                        valid_q         <= 1'b1;
                        state_q         <= StResult;
                    end
                    StResult: begin
                        if (ld_p) begin
                            valid_q <= 1'b0;
                            state_q <= StALo;
                        end
                    end
                    default: begin
                        state_q <= StALo;
                    end
                endcase
            end
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.valid    = valid_q;
    assign bus.stage    = state_q;
    assign bus.load_ack = load_ack_q;

endmodule
